// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default data width and
// FSM state encoding.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor used by the serial datapath.
//   A, B : minuend / subtrahend bits
//   BI   : borrow in
//   D    : difference bit
//   BO   : borrow out
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic D,
  output logic BO
);

  assign D  = A ^ B ^ BI;
  assign BO = (~A & B) | (~(A ^ B) & BI);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes D = A - B - BI over DATA_WIDTH clock cycles,
// LSB first, with borrow-out and two's-complement overflow.
//   CLK, RST      : clock, asynchronous active-low reset
//   START         : request, accepted in IDLE or FINISH
//   A, B, BI      : operands, latched on an accepted START
//   D, BO, V      : result, borrow-out, overflow (valid from DONE onward)
//   BUSY          : high while the state is SHIFT
//   DONE          : one-cycle pulse when D/BO/V update
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  BI,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  BO,
  output logic                  V,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   a_sr;
  logic [DATA_WIDTH-1:0]   b_sr;
  logic [DATA_WIDTH-1:0]   d_sr;
  logic                    br;
  logic                    a_msb;
  logic                    b_msb;

  logic                    load_c;
  logic                    shift_c;
  logic                    last_c;
  logic                    d_bit;
  logic                    bo_bit;
  logic [DATA_WIDTH-1:0]   d_sr_next;

  full_subtractor u_fs (
    .A  (a_sr[0]),
    .B  (b_sr[0]),
    .BI (br),
    .D  (d_bit),
    .BO (bo_bit)
  );

  // New difference bit enters at the MSB; the LSB falls off.
  assign d_sr_next = DATA_WIDTH'({d_bit, d_sr} >> 1);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (START) next_state = SHIFT;
      SHIFT:   if (cnt == CNT_W'(DATA_WIDTH - 1)) next_state = FINISH;
      FINISH:  next_state = START ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath control decode
  always_comb begin
    load_c  = 1'b0;
    shift_c = 1'b0;
    last_c  = 1'b0;
    case (state)
      IDLE:   load_c  = START;
      FINISH: load_c  = START;
      SHIFT: begin
        shift_c = 1'b1;
        last_c  = (cnt == CNT_W'(DATA_WIDTH - 1));
      end
      default: ;
    endcase
  end

  // Operand/result shift registers, counter and borrow
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (load_c) begin
      cnt   <= '0;
      a_sr  <= A;
      b_sr  <= B;
      d_sr  <= '0;
      br    <= BI;
      a_msb <= A[DATA_WIDTH-1];
      b_msb <= B[DATA_WIDTH-1];
    end else if (shift_c) begin
      cnt  <= cnt + CNT_W'(1);
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= d_sr_next;
      br   <= bo_bit;
    end
  end

  // Visible outputs: results only change on the final SHIFT cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      D    <= '0;
      BO   <= 1'b0;
      V    <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      BUSY <= (next_state == SHIFT);
      DONE <= last_c;
      if (last_c) begin
        D  <= d_sr_next;
        BO <= bo_bit;
        // d_bit is the MSB of the final difference
        V  <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at the default width.
module tb_serial_subtractor;

  localparam int unsigned W = 32;

  logic         CLK;
  logic         RST;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BI;
  logic [W-1:0] D;
  logic         BO;
  logic         V;
  logic         BUSY;
  logic         DONE;

  int checks;
  int errors;

  serial_subtractor dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .BI    (BI),
    .D     (D),
    .BO    (BO),
    .V     (V),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request just after an edge; it is sampled on the following edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    START = 1'b1;
    A     = a;
    B     = b;
    BI    = bi;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A     = '1;
    B     = '1;
    BI    = 1'b1;
  endtask

  // Wait for DONE after an accepted request and check the result.
  // inject >= 0 pulses a junk START that many cycles into SHIFT.
  task automatic wait_result(input string tag, input logic [W-1:0] exp_d,
                             input logic exp_bo, input logic exp_v, input int inject);
    int          cycles;
    int          busy_cnt;
    int          changed;
    logic [W-1:0] prev_d;
    cycles   = 0;
    busy_cnt = BUSY ? 1 : 0;
    changed  = 0;
    prev_d   = D;
    while (!DONE && cycles < 100) begin
      @(posedge CLK);
      #1;
      cycles++;
      if (BUSY) busy_cnt++;
      if (!DONE && D !== prev_d) changed++;
      if (cycles == inject) begin
        START = 1'b1;
        A     = 32'h0000_0007;
        B     = 32'h0000_0000;
        BI    = 1'b0;
      end else begin
        START = 1'b0;
      end
    end
    START = 1'b0;
    check({tag, "_latency"}, 64'(cycles), 64'd32);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_no_partial"}, 64'(changed), 64'd0);
    check({tag, "_done"}, 64'(DONE), 64'd1);
    check({tag, "_d"}, 64'(D), 64'(exp_d));
    check({tag, "_bo"}, 64'(BO), 64'(exp_bo));
    check({tag, "_v"}, 64'(V), 64'(exp_v));
  endtask

  // Confirm DONE drops and results hold one cycle later.
  task automatic check_tail(input string tag, input logic [W-1:0] exp_d, input logic exp_bo);
    @(posedge CLK);
    #1;
    check({tag, "_done_low"}, 64'(DONE), 64'd0);
    check({tag, "_busy_low"}, 64'(BUSY), 64'd0);
    check({tag, "_d_hold"}, 64'(D), 64'(exp_d));
    check({tag, "_bo_hold"}, 64'(BO), 64'(exp_bo));
  endtask

  initial begin
    int saw_done;
    checks = 0;
    errors = 0;
    RST    = 1'b0;
    START  = 1'b0;
    A      = '0;
    B      = '0;
    BI     = 1'b0;

    #12;
    check("rst_d", 64'(D), 64'd0);
    check("rst_bo", 64'(BO), 64'd0);
    check("rst_v", 64'(V), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);

    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("idle_busy", 64'(BUSY), 64'd0);

    // 5 - 3
    issue(32'd5, 32'd3, 1'b0);
    check("t1_busy_start", 64'(BUSY), 64'd1);
    wait_result("t1", 32'h0000_0002, 1'b0, 1'b0, -1);
    check_tail("t1", 32'h0000_0002, 1'b0);

    // 0 - 1 wraps with borrow
    issue(32'd0, 32'd1, 1'b0);
    wait_result("t2", 32'hFFFF_FFFF, 1'b1, 1'b0, -1);
    check_tail("t2", 32'hFFFF_FFFF, 1'b1);

    // Reset during SHIFT cycle 10 abandons the operation
    issue(32'h8000_0000, 32'd1, 1'b0);
    repeat (9) begin
      @(posedge CLK);
      #1;
    end
    check("rst_mid_busy_before", 64'(BUSY), 64'd1);
    #3;
    RST = 1'b0;
    #1;
    check("rst_mid_d", 64'(D), 64'd0);
    check("rst_mid_bo", 64'(BO), 64'd0);
    check("rst_mid_v", 64'(V), 64'd0);
    check("rst_mid_busy", 64'(BUSY), 64'd0);
    check("rst_mid_done", 64'(DONE), 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    saw_done = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (DONE || BUSY) saw_done++;
    end
    check("rst_mid_no_done", 64'(saw_done), 64'd0);

    // Signed overflow: most-negative minus one
    issue(32'h8000_0000, 32'd1, 1'b0);
    wait_result("t3", 32'h7FFF_FFFF, 1'b0, 1'b1, -1);
    check_tail("t3", 32'h7FFF_FFFF, 1'b0);

    // Back-to-back, with a stray START mid-SHIFT on the first operation
    issue(32'd10, 32'd3, 1'b1);
    wait_result("b2b1", 32'd6, 1'b0, 1'b0, 5);
    issue(32'd1, 32'd2, 1'b0);
    check("b2b_accept_busy", 64'(BUSY), 64'd1);
    check("b2b_accept_done_low", 64'(DONE), 64'd0);
    check("b2b_d_kept", 64'(D), 64'd6);
    wait_result("b2b2", 32'hFFFF_FFFF, 1'b1, 1'b0, 12);
    check_tail("b2b2", 32'hFFFF_FFFF, 1'b1);

    // Borrow-in consumes the last unit
    issue(32'd5, 32'd5, 1'b1);
    wait_result("t4", 32'hFFFF_FFFF, 1'b1, 1'b0, -1);

    // Positive minus negative overflows into negative
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_result("t5", 32'h8000_0000, 1'b1, 1'b1, -1);
    check_tail("t5", 32'h8000_0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width in bits; legal values 2..64.
REQ-002 Port: CLK  input  1  system clock; all state changes occur on the rising edge.
REQ-003 Port: RST  input  1  asynchronous, active-low reset.
REQ-004 Port: START  input  1  request; sampled on the rising edge of CLK.
REQ-005 Port: A  input  DATA_WIDTH  minuend; captured on an accepted START.
REQ-006 Port: B  input  DATA_WIDTH  subtrahend; captured on an accepted START.
REQ-007 Port: BI  input  1  borrow-in; captured on an accepted START.
REQ-008 Port: D  output  DATA_WIDTH  difference A-B-BI, modulo 2^DATA_WIDTH.
REQ-009 Port: BO  output  1  borrow-out, set when unsigned A < B+BI.
REQ-010 Port: V  output  1  two's-complement overflow of the difference.
REQ-011 Port: BUSY  output  1  high while a subtraction is in progress.
REQ-012 Port: DONE  output  1  one-cycle pulse marking valid D/BO/V.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and FINISH.
REQ-014 START SHALL be accepted only in IDLE or FINISH; an accepted START latches A, B and BI, clears the bit counter, and moves to SHIFT.
REQ-015 START SHALL be ignored in SHIFT, with no effect on latched operands or the counter.
REQ-016 Each SHIFT cycle SHALL process one bit, LSB first, using the registered borrow:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
REQ-017 Each SHIFT cycle SHALL shift the operand registers right by one and insert d at the MSB of the result shift register.
REQ-018 SHIFT SHALL last exactly DATA_WIDTH cycles, then transition to FINISH.
REQ-019 FINISH SHALL last one cycle, then go to IDLE; an accepted START in FINISH goes to SHIFT instead (back-to-back operation).
REQ-020 Latency: for START accepted at edge t0, D/BO/V SHALL update at edge t0+DATA_WIDTH.
REQ-021 DONE SHALL be high from edge t0+DATA_WIDTH to edge t0+DATA_WIDTH+1, and low at all other times.
REQ-022 BUSY SHALL be high from edge t0 to edge t0+DATA_WIDTH, i.e. exactly when the state is SHIFT.
REQ-023 BO SHALL equal the final registered borrow.
REQ-024 V SHALL equal (A[msb] ^ B[msb]) & (A[msb] ^ D[msb]), computed from the latched operands.
REQ-025 D, BO and V SHALL hold their values from the DONE pulse until the next DONE pulse; they SHALL NOT show partial results while BUSY.
REQ-026 Operand inputs SHALL be don't-care except at an accepted START edge.

Reset
REQ-027 RST low SHALL, immediately and regardless of CLK, force:
  - state to IDLE
  - counter, borrow and shift registers to 0
  - D to 0, BO to 0, V to 0, BUSY to 0, DONE to 0
REQ-028 Reset asserted mid-SHIFT SHALL abandon the operation; no DONE pulse SHALL follow.
REQ-029 Reset deassertion SHALL not start an operation; START is honored from the first rising edge after RST goes high.

Structure
REQ-030 The default width SHALL come from the shared project definitions file as the data-width constant; no other shared typedefs are needed.
REQ-031 The per-bit logic SHALL be a separate combinational sub-module, full_subtractor, with ports D, BO, A, B, BI.
REQ-032 full_subtractor SHALL be instantiated once; the top level SHALL hold the FSM, counter and registers.

Verification
REQ-033 A=5, B=3, BI=0, START one cycle -> after 32 cycles, DONE pulses with D=0x00000002, BO=0, V=0; BUSY high for exactly 32 cycles.
REQ-034 A=0, B=1, BI=0 -> D=0xFFFFFFFF, BO=1, V=0.
REQ-035 A=0x80000000, B=1, BI=0 -> D=0x7FFFFFFF, BO=0, V=1.
REQ-036 Back-to-back requests:
  - first: A=10, B=3, BI=1 -> D=6, BO=0
  - second: START held during the DONE cycle with A=1, B=2 -> accepted, next DONE gives D=0xFFFFFFFF, BO=1
  - START pulses mid-SHIFT -> ignored
REQ-037 RST pulsed low at SHIFT cycle 10 -> all outputs 0 asynchronously, no DONE pulse, next START completes correctly in 32 cycles.
